// File: rtl/sqrt_feeder.sv
// sqrt_feeder: operand FIFO and start/busy sequencer in front of an 8-bit integer square-root unit.
// Latency: push to o-valid = 3 cycles + root-unit busy time; a single operation is in flight at a time.
// Backpressure: s_ready_o drops while the FIFO is full; an unconsumed result blocks further issues.
// Optional watchdog on the busy handshake: define SQRT_FEEDER_WDT_EN.
module sqrt_feeder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  input  logic [7:0] s_data_i,
  output logic       m_valid_o,
  input  logic       m_ready_i,
  output logic [3:0] m_data_o,
  output logic [7:0] m_arg_o,
  output logic       sq_start_o,
  output logic [7:0] sq_a_o,
  input  logic       sq_busy_i,
  input  logic [3:0] sq_y_i,
  output logic       err_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_HOLD
  } state_t;

  // Operand storage; pointers carry one extra wrap bit to separate full from empty.
  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        r_in_en;

  // Sequencer state and its registered outputs.
  state_t      r_state;
  logic        r_start;
  logic [7:0]  r_sq_a;
  logic        r_m_valid;
  logic [3:0]  r_m_data;
  logic [7:0]  r_m_arg;

  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic [7:0]  w_head;
  logic        w_timeout;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign s_ready_o = r_in_en & ~w_full;
  assign w_push    = s_valid_i & s_ready_o;
  // The busy term only matters after a watchdog abort left the root unit running;
  // in normal operation busy is already low whenever the sequencer is idle.
  assign w_pop     = (r_state == S_IDLE) & ~w_empty & ~r_m_valid & ~sq_busy_i;
  assign w_head    = r_mem[r_rptr[AW-1:0]];

  assign m_valid_o  = r_m_valid;
  assign m_data_o   = r_m_data;
  assign m_arg_o    = r_m_arg;
  assign sq_start_o = r_start;
  assign sq_a_o     = r_sq_a;

`ifdef SQRT_FEEDER_WDT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_wdt_cnt;
  logic          r_err;

  // Abort when the counter has spent TIMEOUT cycles in the wait states, unless
  // the root unit completes on that same edge.
  assign w_timeout = (r_wdt_cnt == CW'(TIMEOUT - 1)) &&
                     ((r_state == S_WAIT_HI) || ((r_state == S_WAIT_LO) && sq_busy_i));
  assign err_o     = r_err;

  // Watchdog counter: cleared when an operand is popped, counts while waiting on busy.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wdt_cnt <= '0;
    end else if (w_pop) begin
      r_wdt_cnt <= '0;
    end else if (((r_state == S_WAIT_HI) || (r_state == S_WAIT_LO)) && !w_timeout) begin
      r_wdt_cnt <= r_wdt_cnt + CW'(1);
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end
`else
  // No watchdog: waits are unbounded and the error flag is a constant zero
  // (the comparison folds away; it keeps TIMEOUT referenced in this build).
  assign w_timeout = 1'b0;
  assign err_o     = (TIMEOUT < 0) ? 1'b1 : 1'b0;
`endif

  // Input stream enable: held low in reset, opens on the first edge after release.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_in_en <= 1'b0;
    end else begin
      r_in_en <= 1'b1;
    end
  end

  // FIFO storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= s_data_i;
    end
  end

  // FIFO pointers; push and pop may happen on the same edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Issue/capture sequencer with registered handshake and result outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_start   <= 1'b0;
      r_sq_a    <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_arg   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_sq_a  <= w_head;
            r_start <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Start is high for exactly this one cycle.
          r_start <= 1'b0;
          r_state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (w_timeout) begin
            r_m_data  <= 4'hF;
            r_m_arg   <= r_sq_a;
            r_m_valid <= 1'b1;
            r_state   <= S_HOLD;
          end else if (sq_busy_i) begin
            r_state <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          // The root is valid on the first low cycle of busy.
          if (!sq_busy_i) begin
            r_m_data  <= sq_y_i;
            r_m_arg   <= r_sq_a;
            r_m_valid <= 1'b1;
            r_state   <= S_HOLD;
          end else if (w_timeout) begin
            r_m_data  <= 4'hF;
            r_m_arg   <= r_sq_a;
            r_m_valid <= 1'b1;
            r_state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Result stays frozen until the consumer takes it.
          if (r_m_valid && m_ready_i) begin
            r_m_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_start   <= 1'b0;
          r_m_valid <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_feeder.sv
// Testbench for sqrt_feeder: behavioural root-unit stub plus queue-based reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
// Build with SQRT_FEEDER_WDT_EN defined to include the watchdog scenario.
module tb_sqrt_feeder;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] m_data;
  logic [7:0] m_arg;
  logic       sq_start;
  logic [7:0] sq_a;
  logic       sq_busy;
  logic [3:0] sq_y;
  logic       err;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int n_start = 0;
  int n_bad   = 0;

  // Root-unit stub state.
  logic       r_busy;
  logic       stuck;
  int         busy_cnt;
  logic [7:0] a_lat;
  logic [3:0] y_reg;

  always #5 clk = ~clk;

  sqrt_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_arg_o(m_arg),
    .sq_start_o(sq_start), .sq_a_o(sq_a), .sq_busy_i(sq_busy), .sq_y_i(sq_y),
    .err_o(err)
  );

  // Reference root: largest r with r*r <= a.
  function automatic logic [3:0] isqrt(input logic [7:0] a);
    logic [3:0] r = 4'd0;
    for (int i = 0; i < 16; i++) if (i * i <= int'(a)) r = 4'(i);
    return r;
  endfunction

  // Busy duration of the modelled root unit: 9..13 cycles, 9 for operand 0.
  function automatic int root_cycles(input logic [7:0] a);
    return 9 + int'(a) % 5;
  endfunction

  assign sq_busy = r_busy | stuck;
  assign sq_y    = y_reg;

  // Root-unit stub: busy rises on the edge that samples start; root valid when busy falls.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0; busy_cnt <= 0; a_lat <= 8'd0; y_reg <= 4'd0;
    end else if (sq_start && !r_busy) begin
      r_busy <= 1'b1; busy_cnt <= root_cycles(sq_a) - 1; a_lat <= sq_a; y_reg <= 4'hA;
    end else if (r_busy) begin
      if (busy_cnt == 0) begin
        r_busy <= 1'b0; y_reg <= isqrt(a_lat);
      end else begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  // Edge counter, start-pulse counter and handshake-rule violation counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sq_start) n_start <= n_start + 1;
    if ((sq_start && r_busy) || (r_busy && sq_a !== a_lat)) n_bad <= n_bad + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'd0; m_ready = 1'b0; stuck = 1'b0;
    repeat (3) tick();
    checks++;
    if ({s_ready, m_valid, m_data, m_arg, sq_start, sq_a, err} !== 24'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 000000", {s_ready, m_valid, m_data, m_arg, sq_start, sq_a, err});
    end
    rst_n = 1'b1;
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_before_edge got %b want 0", s_ready); end
    tick();
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after_edge got %b want 1", s_ready); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ops [5]   = '{8'd0, 8'd1, 8'd63, 8'd64, 8'd255};
    logic [3:0] roots [5] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd15};
    int idx = 0, got = 0, t_push = 0, lat = -1, budget = 0;
    int s0 = n_start;
    m_ready = 1'b1;
    while (got < 5 && budget < 400) begin
      if (m_valid && m_ready) begin
        checks++;
        if (m_arg !== ops[got] || m_data !== roots[got]) begin
          errors++;
          $display("FAIL b2b_result[%0d] got (%0d,%0d) want (%0d,%0d)", got, m_arg, m_data, ops[got], roots[got]);
        end
        if (got == 0) lat = cyc - t_push;
        got++;
      end
      if (idx < 5) begin
        s_valid = 1'b1; s_data = ops[idx];
        if (s_ready) begin
          if (idx == 0) t_push = cyc;
          idx++;
        end
      end else begin
        s_valid = 1'b0;
      end
      tick(); budget++;
    end
    s_valid = 1'b0;
    checks++;
    if (got != 5) begin errors++; $display("FAIL b2b_count got %0d want 5", got); end
    // Operand 0 on an idle pipe: 1 push + 1 idle + 1 issue + 9 busy + 1 capture.
    checks++;
    if (lat != 13) begin errors++; $display("FAIL b2b_latency got %0d want 13", lat); end
    checks++;
    if (n_start - s0 != 5) begin errors++; $display("FAIL b2b_starts got %0d want 5", n_start - s0); end
    checks++;
    if (n_bad != 0) begin errors++; $display("FAIL b2b_start_rules got %0d want 0", n_bad); end
  endtask

  task automatic test_backpressure();
    logic [7:0] ops [6];
    logic [7:0] q [$];
    logic [7:0] exp_a;
    int idx = 0, got = 0, budget = 0;
    bit window_ok = 1'b1;
    for (int i = 0; i < 6; i++) ops[i] = 8'($urandom);
    m_ready = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (idx < 6) begin
        s_valid = 1'b1; s_data = ops[idx];
        if (s_ready) begin q.push_back(ops[idx]); idx++; end
      end
      tick();
    end
    checks++;
    if (idx != DEPTH + 1) begin errors++; $display("FAIL bp_accepted got %0d want %0d", idx, DEPTH + 1); end
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %b want 0", s_ready); end
    checks++;
    if (m_valid !== 1'b1 || m_arg !== ops[0] || m_data !== isqrt(ops[0])) begin
      errors++;
      $display("FAIL bp_first_result got v=%b (%0d,%0d) want v=1 (%0d,%0d)", m_valid, m_arg, m_data, ops[0], isqrt(ops[0]));
    end
    // FIFO full with the last operand still offered: nothing may enter, result frozen.
    for (int c = 0; c < 10; c++) begin
      if (s_ready !== 1'b0 || m_arg !== ops[0] || m_data !== isqrt(ops[0])) window_ok = 1'b0;
      tick();
    end
    checks++;
    if (!window_ok || idx != DEPTH + 1) begin
      errors++; $display("FAIL bp_full_window got ok=%b accepted=%0d want ok=1 accepted=%0d", window_ok, idx, DEPTH + 1);
    end
    m_ready = 1'b1;
    while (got < 6 && budget < 400) begin
      if (m_valid && m_ready) begin
        exp_a = q.pop_front();
        checks++;
        if (m_arg !== exp_a || m_data !== isqrt(exp_a)) begin
          errors++;
          $display("FAIL bp_drain[%0d] got (%0d,%0d) want (%0d,%0d)", got, m_arg, m_data, exp_a, isqrt(exp_a));
        end
        got++;
      end
      if (idx < 6) begin
        s_valid = 1'b1; s_data = ops[idx];
        if (s_ready) begin q.push_back(ops[idx]); idx++; end
      end else begin
        s_valid = 1'b0;
      end
      tick(); budget++;
    end
    s_valid = 1'b0;
    checks++;
    if (got != 6) begin errors++; $display("FAIL bp_drain_count got %0d want 6", got); end
  endtask

  task automatic test_hold();
    int budget = 0, s0;
    bit stable = 1'b1;
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'd144;
    tick();
    s_valid = 1'b0;
    while (!m_valid && budget < 100) begin tick(); budget++; end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 4'd12 || m_arg !== 8'd144) begin
      errors++; $display("FAIL hold_result got v=%b (%0d,%0d) want v=1 (144,12)", m_valid, m_arg, m_data);
    end
    s0 = n_start;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (m_valid !== 1'b1 || m_data !== 4'd12 || m_arg !== 8'd144) stable = 1'b0;
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL hold_stable got unstable want (144,12) held"); end
    checks++;
    if (n_start != s0) begin errors++; $display("FAIL hold_no_start got %0d starts want 0", n_start - s0); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL hold_release got %b want 0", m_valid); end
  endtask

  task automatic test_reset_in_flight();
    int budget = 0;
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'd200;
    tick();
    s_valid = 1'b0;
    while (!sq_busy && budget < 20) begin tick(); budget++; end
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, m_valid, m_data, m_arg, sq_start, sq_a, err} !== 24'd0) begin
      errors++;
      $display("FAIL flight_reset_outputs got %h want 000000", {s_ready, m_valid, m_data, m_arg, sq_start, sq_a, err});
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL flight_ready_after got %b want 1", s_ready); end
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 8'd9;
    tick();
    s_valid = 1'b0;
    budget = 0;
    while (!m_valid && budget < 100) begin tick(); budget++; end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 4'd3 || m_arg !== 8'd9) begin
      errors++; $display("FAIL flight_after_reset got v=%b (%0d,%0d) want v=1 (9,3)", m_valid, m_arg, m_data);
    end
    tick();
    m_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    logic [7:0] exp_a;
    int idx = 0, got = 0, budget = 0;
    int s0 = n_start;
    while (got < 40 && budget < 4000) begin
      m_ready = ($urandom_range(0, 1) == 1);
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          errors++; checks++; $display("FAIL rand_unexpected got (%0d,%0d) want none", m_arg, m_data);
        end else begin
          exp_a = q.pop_front();
          checks++;
          if (m_arg !== exp_a || m_data !== isqrt(exp_a)) begin
            errors++;
            $display("FAIL rand_result[%0d] got (%0d,%0d) want (%0d,%0d)", got, m_arg, m_data, exp_a, isqrt(exp_a));
          end
        end
        got++;
      end
      if (idx < 40 && (s_valid || $urandom_range(0, 9) < 7)) begin
        if (!s_valid) s_data = 8'($urandom);
        s_valid = 1'b1;
        if (s_ready) begin q.push_back(s_data); idx++; end
      end else begin
        s_valid = 1'b0;
      end
      tick(); budget++;
      // An accepted beat is replaced by a fresh operand on the next cycle.
      if (s_valid && q.size() > 0 && idx > 0) s_valid = 1'b0;
    end
    s_valid = 1'b0; m_ready = 1'b0;
    checks++;
    if (got != 40) begin errors++; $display("FAIL rand_count got %0d want 40", got); end
    checks++;
    if (n_start - s0 != 40) begin errors++; $display("FAIL rand_starts got %0d want 40", n_start - s0); end
    checks++;
    if (n_bad != 0 || err !== 1'b0) begin errors++; $display("FAIL rand_rules got bad=%0d err=%b want 0 0", n_bad, err); end
  endtask

`ifdef SQRT_FEEDER_WDT_EN
  task automatic test_wdt();
    int budget = 0, t_s = 0, t_v = 0;
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'd50;
    tick();
    s_valid = 1'b0;
    while (!sq_start && budget < 20) begin tick(); budget++; end
    t_s = cyc;
    stuck = 1'b1;
    budget = 0;
    while (!m_valid && budget < 200) begin tick(); budget++; end
    t_v = cyc;
    // Start seen in ISSUE; WAIT_HI begins one edge later, abort TIMEOUT edges after that.
    checks++;
    if (t_v - t_s != TIMEOUT + 1) begin errors++; $display("FAIL wdt_latency got %0d want %0d", t_v - t_s, TIMEOUT + 1); end
    checks++;
    if (err !== 1'b1 || m_data !== 4'hF || m_arg !== 8'd50) begin
      errors++; $display("FAIL wdt_result got err=%b (%0d,%h) want err=1 (50,f)", err, m_arg, m_data);
    end
    m_ready = 1'b1; stuck = 1'b0;
    repeat (3) tick();
    m_ready = 1'b0;
    checks++;
    if (err !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL wdt_sticky got err=%b v=%b want err=1 v=0", err, m_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_hold();
    test_reset_in_flight();
    test_random();
`ifdef SQRT_FEEDER_WDT_EN
    test_wdt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
